// File: rtl/vga_timing_pkg.sv
// Shared constants, width helper and sync bundle for the VGA timing path.
// Defaults describe the standard 640x480 @ 60 Hz mode.
package vga_timing_pkg;

   localparam int DEF_TOTAL_COLS  = 800;
   localparam int DEF_TOTAL_ROWS  = 525;
   localparam int DEF_ACTIVE_COLS = 640;
   localparam int DEF_ACTIVE_ROWS = 480;
   localparam int DEF_H_FRONT     = 16;
   localparam int DEF_H_SYNC      = 96;
   localparam int DEF_V_FRONT     = 10;
   localparam int DEF_V_SYNC      = 2;
   localparam int MAX_USER_LAT    = 8;

   localparam int DEF_H_BACK = DEF_TOTAL_COLS - DEF_ACTIVE_COLS
                             - DEF_H_FRONT - DEF_H_SYNC;
   localparam int DEF_V_BACK = DEF_TOTAL_ROWS - DEF_ACTIVE_ROWS
                             - DEF_V_FRONT - DEF_V_SYNC;

   typedef struct packed {
      logic hs;
      logic vs;
      logic act;
   } sync_t;

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// Enable-gated column/row scan counters with frame-start flag.
module vga_timing_counter
   import vga_timing_pkg::*;
#(
   parameter int TOTAL_COLS = DEF_TOTAL_COLS,
   parameter int TOTAL_ROWS = DEF_TOTAL_ROWS,
   localparam int CW = cnt_width(TOTAL_COLS),
   localparam int RW = cnt_width(TOTAL_ROWS)
) (
   input  logic          i_Clk,
   input  logic          i_Rst_n,
   input  logic          i_Pix_En,
   output logic [CW-1:0] o_Col_Count,
   output logic [RW-1:0] o_Row_Count,
   output logic          o_Frame_Start
);

   logic [CW-1:0] r_Col;
   logic [RW-1:0] r_Row;
   logic          w_Col_Wrap;
   logic          w_Row_Wrap;

   assign w_Col_Wrap = (r_Col == CW'(TOTAL_COLS - 1));
   assign w_Row_Wrap = (r_Row == RW'(TOTAL_ROWS - 1));

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_Col <= '0;
         r_Row <= '0;
      end else if (i_Pix_En) begin
         if (w_Col_Wrap) begin
            r_Col <= '0;
            r_Row <= w_Row_Wrap ? '0 : r_Row + RW'(1);
         end else begin
            r_Col <= r_Col + CW'(1);
         end
      end
   end

   // Gated by reset so the flag is quiet while the block is held.
   assign o_Frame_Start = i_Rst_n & i_Pix_En
                        & (r_Col == '0) & (r_Row == '0);

   assign o_Col_Count = r_Col;
   assign o_Row_Count = r_Row;

endmodule

// File: rtl/vga_sync_timing_gen.sv
// VGA timing generator: counters, sync decode, pixel-latency delay line
// and aligned, blanked output register.
module vga_sync_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int   VIDEO_WIDTH = 3,
   parameter int   TOTAL_COLS  = DEF_TOTAL_COLS,
   parameter int   TOTAL_ROWS  = DEF_TOTAL_ROWS,
   parameter int   ACTIVE_COLS = DEF_ACTIVE_COLS,
   parameter int   ACTIVE_ROWS = DEF_ACTIVE_ROWS,
   parameter int   H_FRONT     = DEF_H_FRONT,
   parameter int   H_SYNC      = DEF_H_SYNC,
   parameter int   V_FRONT     = DEF_V_FRONT,
   parameter int   V_SYNC      = DEF_V_SYNC,
   parameter logic SYNC_POL    = 1'b0,
   parameter int   USER_LAT    = 1,
   localparam int  CW = cnt_width(TOTAL_COLS),
   localparam int  RW = cnt_width(TOTAL_ROWS)
) (
   input  logic                   i_Clk,
   input  logic                   i_Rst_n,
   input  logic                   i_Pix_En,
   input  logic [VIDEO_WIDTH-1:0] i_Red_Video,
   input  logic [VIDEO_WIDTH-1:0] i_Grn_Video,
   input  logic [VIDEO_WIDTH-1:0] i_Blu_Video,
   output logic [CW-1:0]          o_Col_Count,
   output logic [RW-1:0]          o_Row_Count,
   output logic                   o_Frame_Start,
   output logic                   o_HSync,
   output logic                   o_VSync,
   output logic                   o_Active,
   output logic [VIDEO_WIDTH-1:0] o_Red_Video,
   output logic [VIDEO_WIDTH-1:0] o_Grn_Video,
   output logic [VIDEO_WIDTH-1:0] o_Blu_Video
);

   localparam int H_SS = ACTIVE_COLS + H_FRONT;
   localparam int H_SE = H_SS + H_SYNC;
   localparam int V_SS = ACTIVE_ROWS + V_FRONT;
   localparam int V_SE = V_SS + V_SYNC;

   if (H_SE >= TOTAL_COLS || V_SE >= TOTAL_ROWS ||
       USER_LAT < 0 || USER_LAT > MAX_USER_LAT) begin : g_bad_params
      $fatal(1, "vga_sync_timing_gen: illegal timing parameters");
   end

   logic [CW-1:0]          w_Col;
   logic [RW-1:0]          w_Row;
   sync_t                  w_Raw;
   sync_t                  w_Dly;
   logic                   r_HSync;
   logic                   r_VSync;
   logic                   r_Active;
   logic [VIDEO_WIDTH-1:0] r_Red;
   logic [VIDEO_WIDTH-1:0] r_Grn;
   logic [VIDEO_WIDTH-1:0] r_Blu;

   vga_timing_counter #(
      .TOTAL_COLS (TOTAL_COLS),
      .TOTAL_ROWS (TOTAL_ROWS)
   ) u_counter (
      .i_Clk         (i_Clk),
      .i_Rst_n       (i_Rst_n),
      .i_Pix_En      (i_Pix_En),
      .o_Col_Count   (w_Col),
      .o_Row_Count   (w_Row),
      .o_Frame_Start (o_Frame_Start)
   );

   // Raw decode in asserted sense; polarity is applied at the pins.
   assign w_Raw.act = (w_Col < CW'(ACTIVE_COLS))
                    && (w_Row < RW'(ACTIVE_ROWS));
   assign w_Raw.hs  = (w_Col >= CW'(H_SS)) && (w_Col < CW'(H_SE));
   assign w_Raw.vs  = (w_Row >= RW'(V_SS)) && (w_Row < RW'(V_SE));

   if (USER_LAT == 0) begin : g_no_dly
      assign w_Dly = w_Raw;
   end else begin : g_dly
      sync_t r_Dly [USER_LAT];

      always_ff @(posedge i_Clk or negedge i_Rst_n) begin
         if (!i_Rst_n) begin
            for (int i = 0; i < USER_LAT; i++) r_Dly[i] <= '0;
         end else if (i_Pix_En) begin
            r_Dly[0] <= w_Raw;
            for (int i = 1; i < USER_LAT; i++) r_Dly[i] <= r_Dly[i-1];
         end
      end

      assign w_Dly = r_Dly[USER_LAT-1];
   end

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_HSync  <= ~SYNC_POL;
         r_VSync  <= ~SYNC_POL;
         r_Active <= 1'b0;
         r_Red    <= '0;
         r_Grn    <= '0;
         r_Blu    <= '0;
      end else if (i_Pix_En) begin
         r_HSync  <= w_Dly.hs ? SYNC_POL : ~SYNC_POL;
         r_VSync  <= w_Dly.vs ? SYNC_POL : ~SYNC_POL;
         r_Active <= w_Dly.act;
         r_Red    <= w_Dly.act ? i_Red_Video : '0;
         r_Grn    <= w_Dly.act ? i_Grn_Video : '0;
         r_Blu    <= w_Dly.act ? i_Blu_Video : '0;
      end
   end

   assign o_Col_Count = w_Col;
   assign o_Row_Count = w_Row;
   assign o_HSync     = r_HSync;
   assign o_VSync     = r_VSync;
   assign o_Active    = r_Active;
   assign o_Red_Video = r_Red;
   assign o_Grn_Video = r_Grn;
   assign o_Blu_Video = r_Blu;

endmodule

// File: tb/tb_vga_sync_timing_gen.sv
// Scoreboard bench: three small-mode instances (latency 1/0/3, mixed
// polarity) driven by random enables and colour, checked against a model.
module tb_vga_sync_timing_gen;

   localparam int TC = 10;
   localparam int TR = 6;
   localparam int AC = 4;
   localparam int AR = 3;
   localparam int HF = 1;
   localparam int HS = 2;
   localparam int VF = 1;
   localparam int VS = 1;
   localparam int VW = 3;
   localparam int N  = 3;

   typedef struct packed {
      logic hs;
      logic vs;
      logic act;
   } raw_t;

   typedef struct packed {
      logic          hs;
      logic          vs;
      logic          act;
      logic [VW-1:0] r;
      logic [VW-1:0] g;
      logic [VW-1:0] b;
   } pin_t;

   typedef struct packed {
      logic [3:0]        col;
      logic [2:0]        row;
      logic              fs;
      pin_t [N-1:0]      o;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          en = 1'b0;
   logic [VW-1:0] r_in = '0;
   logic [VW-1:0] g_in = '0;
   logic [VW-1:0] b_in = '0;

   logic [3:0]    col [N];
   logic [2:0]    row [N];
   logic          fs  [N];
   logic          hs  [N];
   logic          vs  [N];
   logic          act [N];
   logic [VW-1:0] ro  [N];
   logic [VW-1:0] go  [N];
   logic [VW-1:0] bo  [N];

   int   lat [N] = '{1, 0, 3};
   logic pol [N] = '{1'b0, 1'b0, 1'b1};

   int   n_chk = 0;
   int   n_fail = 0;
   exp_t sbq [$];

   int      mcol, mrow, step;
   raw_t    hist [$];
   pin_t    cur [N];
   logic    en_prev;
   logic [VW-1:0] rp, gp, bp;
   logic    did_rst = 1'b0;

   always #5 clk = ~clk;

   vga_sync_timing_gen #(
      .VIDEO_WIDTH(VW), .TOTAL_COLS(TC), .TOTAL_ROWS(TR),
      .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR), .H_FRONT(HF), .H_SYNC(HS),
      .V_FRONT(VF), .V_SYNC(VS), .SYNC_POL(1'b0), .USER_LAT(1)
   ) u_a (
      .i_Clk(clk), .i_Rst_n(rst_n), .i_Pix_En(en),
      .i_Red_Video(r_in), .i_Grn_Video(g_in), .i_Blu_Video(b_in),
      .o_Col_Count(col[0]), .o_Row_Count(row[0]),
      .o_Frame_Start(fs[0]), .o_HSync(hs[0]), .o_VSync(vs[0]),
      .o_Active(act[0]), .o_Red_Video(ro[0]), .o_Grn_Video(go[0]),
      .o_Blu_Video(bo[0])
   );

   vga_sync_timing_gen #(
      .VIDEO_WIDTH(VW), .TOTAL_COLS(TC), .TOTAL_ROWS(TR),
      .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR), .H_FRONT(HF), .H_SYNC(HS),
      .V_FRONT(VF), .V_SYNC(VS), .SYNC_POL(1'b0), .USER_LAT(0)
   ) u_b (
      .i_Clk(clk), .i_Rst_n(rst_n), .i_Pix_En(en),
      .i_Red_Video(r_in), .i_Grn_Video(g_in), .i_Blu_Video(b_in),
      .o_Col_Count(col[1]), .o_Row_Count(row[1]),
      .o_Frame_Start(fs[1]), .o_HSync(hs[1]), .o_VSync(vs[1]),
      .o_Active(act[1]), .o_Red_Video(ro[1]), .o_Grn_Video(go[1]),
      .o_Blu_Video(bo[1])
   );

   vga_sync_timing_gen #(
      .VIDEO_WIDTH(VW), .TOTAL_COLS(TC), .TOTAL_ROWS(TR),
      .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR), .H_FRONT(HF), .H_SYNC(HS),
      .V_FRONT(VF), .V_SYNC(VS), .SYNC_POL(1'b1), .USER_LAT(3)
   ) u_c (
      .i_Clk(clk), .i_Rst_n(rst_n), .i_Pix_En(en),
      .i_Red_Video(r_in), .i_Grn_Video(g_in), .i_Blu_Video(b_in),
      .o_Col_Count(col[2]), .o_Row_Count(row[2]),
      .o_Frame_Start(fs[2]), .o_HSync(hs[2]), .o_VSync(vs[2]),
      .o_Active(act[2]), .o_Red_Video(ro[2]), .o_Grn_Video(go[2]),
      .o_Blu_Video(bo[2])
   );

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t",
                  name, got, want, $time);
      end
   endtask

   function automatic raw_t raw_of(input int c, input int r);
      raw_t x;
      x.act = (c < AC) && (r < AR);
      x.hs  = (c >= AC + HF) && (c < AC + HF + HS);
      x.vs  = (r >= AR + VF) && (r < AR + VF + VS);
      return x;
   endfunction

   function automatic pin_t idle(input int i);
      pin_t p;
      p = '0;
      p.hs = ~pol[i];
      p.vs = ~pol[i];
      return p;
   endfunction

   task automatic compare_all(input exp_t e);
      for (int i = 0; i < N; i++) begin
         chk($sformatf("col%0d", i), 32'(col[i]), 32'(e.col));
         chk($sformatf("row%0d", i), 32'(row[i]), 32'(e.row));
         chk($sformatf("fs%0d", i), 32'(fs[i]), 32'(e.fs));
         chk($sformatf("hs%0d", i), 32'(hs[i]), 32'(e.o[i].hs));
         chk($sformatf("vs%0d", i), 32'(vs[i]), 32'(e.o[i].vs));
         chk($sformatf("act%0d", i), 32'(act[i]), 32'(e.o[i].act));
         chk($sformatf("red%0d", i), 32'(ro[i]), 32'(e.o[i].r));
         chk($sformatf("grn%0d", i), 32'(go[i]), 32'(e.o[i].g));
         chk($sformatf("blu%0d", i), 32'(bo[i]), 32'(e.o[i].b));
      end
   endtask

   task automatic model_reset();
      mcol = 0;
      mrow = 0;
      step = 0;
      hist.delete();
      for (int i = 0; i < N; i++) cur[i] = idle(i);
   endtask

   // One enabled pixel step: output shows the raw timing of the count
   // presented lat steps earlier, with the colour driven on this step.
   task automatic model_edge();
      raw_t x;
      hist.push_back(raw_of(mcol, mrow));
      for (int i = 0; i < N; i++) begin
         x = (step >= lat[i]) ? hist[step - lat[i]] : '0;
         cur[i].hs  = x.hs ? pol[i] : ~pol[i];
         cur[i].vs  = x.vs ? pol[i] : ~pol[i];
         cur[i].act = x.act;
         cur[i].r   = x.act ? rp : '0;
         cur[i].g   = x.act ? gp : '0;
         cur[i].b   = x.act ? bp : '0;
      end
      step++;
      mcol++;
      if (mcol == TC) begin
         mcol = 0;
         mrow = (mrow + 1) % TR;
      end
   endtask

   function automatic exp_t snap(input logic fs_exp);
      exp_t e;
      e.col = 4'(mcol);
      e.row = 3'(mrow);
      e.fs  = fs_exp;
      for (int i = 0; i < N; i++) e.o[i] = cur[i];
      return e;
   endfunction

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            compare_all(e);
         end
      end
   end

   initial begin : driver
      logic force_en;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      compare_all(snap(1'b0));
      rst_n = 1'b1;
      force_en = 1'b1;
      for (int cyc = 0; cyc < 1600; cyc++) begin
         if (!did_rst && cyc >= 900 && mcol == 7 && mrow == 2) begin
            en = 1'b1;
            rst_n = 1'b0;
            #1;
            model_reset();
            compare_all(snap(1'b0));
            @(posedge clk);
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            did_rst = 1'b1;
            force_en = 1'b1;
         end
         if (force_en || cyc < 240) en = 1'b1;
         else if (cyc < 720) en = (cyc % 4 == 0);
         else en = ($urandom % 3) != 0;
         force_en = 1'b0;
         r_in = VW'($urandom);
         g_in = VW'($urandom);
         b_in = VW'($urandom);
         en_prev = en;
         rp = r_in;
         gp = g_in;
         bp = b_in;
         sbq.push_back(snap(en && mcol == 0 && mrow == 0));
         @(posedge clk);
         #1;
         if (en_prev) model_edge();
      end
      @(negedge clk);
      #1;
      chk("reset_hit", 32'(did_rst), 32'd1);
      chk("sb_drain", 32'(sbq.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
